i2c_touch_sequencer: RTL and testbench

Autonomous bus-master sequencer for the I2C touch-controller peripheral. On a trigger it programs the I2C slave's divisor and byte-enable registers, then performs NUM_READS command/read transactions. For each transaction it polls the idle flag, with a timeout, and streams each 32-bit result out on a valid/ready port. It sits between the touch interrupt and the I2C register slave, so the CPU no longer has to run the touch-read loop.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/seq_down_counter.sv | 33 +++
 rtl/i2c_touch_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_touch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C touch-controller sequencer.
// Contents: sequencer state enum, slave register addresses, and the bit
// position of the idle flag in the control/status register.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrDvsr,
    StWrBen,
    StWrCmd,
    StSettleW,
    StPollA,
    StPollS,
    StRdA,
    StRdS,
    StPush,
    StDone,
    StErr
  } seq_state_e;

  localparam logic [1:0] I2C_ADDR_DATA = 2'd0;
  localparam logic [1:0] I2C_ADDR_CTRL = 2'd1;
  localparam logic [1:0] I2C_ADDR_BEN  = 2'd2;
  localparam logic [1:0] I2C_ADDR_DVSR = 2'd3;

  localparam int unsigned I2C_IDLE_BIT = 19;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag.
// Ports:
//   clk, reset - clock, asynchronous active-high reset (count clears to 0)
//   load       - load load_val (has priority over dec)
//   load_val   - value to load
//   dec        - decrement by one; saturates at zero
//   zero       - count is zero
module seq_down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_touch_sequencer.sv
// Autonomous bus master for the I2C touch-controller slave. On trig it writes
// the divisor and byte-enable registers, then runs NUM_READS command/poll/read
// transactions and streams each 32-bit result on a valid/ready port.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   trig                  - start pulse, accepted only when idle
//   busy, done, error     - status (done/error are one-cycle pulses)
//   m_chipselect, m_write - bus strobes (write states only)
//   m_address, m_writedata, m_readdata - slave register bus
//   res_valid, res_data, res_ready     - result stream
// All outputs are registered: next-cycle outputs are decoded from the next
// state, so every strobe lines up exactly with its state.
module i2c_touch_sequencer
  import i2c_pkg::*;
#(
  parameter logic [15:0] DVSR       = 16'd250,
  parameter logic [1:0]  BEN        = 2'b11,
  parameter logic [31:0] CMD_BASE   = 32'h0000_0000,
  parameter int unsigned NUM_READS  = 4,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [1:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        res_valid,
  output logic [31:0] res_data,
  input  logic        res_ready
);

  localparam int unsigned KW = (NUM_READS > 1) ? $clog2(NUM_READS) : 1;
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  localparam logic [KW-1:0] KLast = KW'(NUM_READS - 1);

  seq_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        cs_q, cs_d, we_q, we_d, valid_q, valid_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;

  logic settle_load, settle_dec, settle_zero;
  logic poll_load, poll_dec, poll_zero;

  // Both counters are loaded with N-1 and the exit happens on zero, so the
  // settle wait lasts SETTLE cycles and the poll loop takes POLL_LIMIT samples.
  seq_down_counter #(.Width(SW)) u_settle_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (settle_load),
    .load_val (SW'(SETTLE - 1)),
    .dec      (settle_dec),
    .zero     (settle_zero)
  );

  seq_down_counter #(.Width(PW)) u_poll_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (poll_load),
    .load_val (PW'(POLL_LIMIT - 1)),
    .dec      (poll_dec),
    .zero     (poll_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rdata_d     = rdata_q;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    poll_load   = 1'b0;
    poll_dec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig) begin
          state_d = StWrDvsr;
          k_d     = '0;
        end
      end
      StWrDvsr: state_d = StWrBen;
      StWrBen:  state_d = StWrCmd;
      StWrCmd: begin
        settle_load = 1'b1;
        state_d     = StSettleW;
      end
      StSettleW: begin
        if (settle_zero) begin
          poll_load = 1'b1;
          state_d   = StPollA;
        end else begin
          settle_dec = 1'b1;
        end
      end
      StPollA: state_d = StPollS;
      StPollS: begin
        if (m_readdata[I2C_IDLE_BIT]) begin
          state_d = StRdA;
        end else if (poll_zero) begin
          state_d = StErr;
        end else begin
          poll_dec = 1'b1;
          state_d  = StPollA;
        end
      end
      StRdA: state_d = StRdS;
      StRdS: begin
        rdata_d = m_readdata;
        state_d = StPush;
      end
      StPush: begin
        if (valid_q && res_ready) begin
          if (k_q == KLast) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = StWrCmd;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered-output decode from the next state.
  always_comb begin
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
    valid_d = (state_d == StPush);
    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_d)
      StWrDvsr: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = I2C_ADDR_DVSR;
        wdata_d = {16'b0, DVSR};
      end
      StWrBen: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = I2C_ADDR_BEN;
        wdata_d = {30'b0, BEN};
      end
      StWrCmd: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = I2C_ADDR_DATA;
        wdata_d = CMD_BASE + 32'(k_d);
      end
      // Reads are address-only: the slave decodes m_address without a select.
      StPollA, StPollS: addr_d = I2C_ADDR_CTRL;
      StRdA, StRdS:     addr_d = I2C_ADDR_DATA;
      default: ;
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign m_chipselect = cs_q;
  assign m_write      = we_q;
  assign m_address    = addr_q;
  assign m_writedata  = wdata_q;
  assign res_valid    = valid_q;
  assign res_data     = rdata_q;

endmodule

// File: tb/tb_i2c_touch_sequencer.sv
// Self-checking bench for i2c_touch_sequencer with a behavioural slave model,
// directed scenarios and randomized scans.
module tb_i2c_touch_sequencer;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int PL = 8;
  localparam logic [31:0] CB = 32'h40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trig = 1'b0;
  logic        res_ready = 1'b1;
  logic        busy, done, error, m_chipselect, m_write, res_valid;
  logic [1:0]  m_address;
  logic [31:0] m_writedata, res_data;
  logic [31:0] m_readdata = '0;

  int checks = 0;
  int errors = 0;

  i2c_touch_sequencer #(
    .DVSR       (16'd250),
    .BEN        (2'b11),
    .CMD_BASE   (CB),
    .NUM_READS  (N),
    .SETTLE     (S),
    .POLL_LIMIT (PL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .trig         (trig),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: idle flag rises idle_delay cycles after a command write;
  // data register returns resp[] indexed by the command offset.
  logic [31:0] resp [16];
  logic [31:0] cmd_reg = '0;
  logic [31:0] off;
  int  since = 0;
  int  idle_delay = 10;
  bit  idle_force = 0;
  bit  idle_stuck = 0;
  bit  idle_now;

  always @(posedge clk) begin
    if (m_write && m_address == 2'd0) begin
      cmd_reg = m_writedata;
      since   = 0;
    end else if (since < 100000) begin
      since++;
    end
    idle_now = idle_force || (!idle_stuck && since >= idle_delay);
    off = cmd_reg - CB;
    case (m_address)
      2'd1:    m_readdata <= idle_now ? (32'd1 << 19) : 32'd0;
      2'd0:    m_readdata <= resp[off[3:0]];
      default: m_readdata <= 32'd0;
    endcase
  end

  // Bus/stream monitor, sampled on the falling edge.
  logic [33:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] res_q[$];
  int          rv_cyc_q[$];
  int done_cnt, err_cnt, done_cyc, err_cyc, unstable, push_bus;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_addr = '0;

  always @(negedge clk) begin
    if (m_write) begin
      wr_q.push_back({m_address, m_writedata});
      wr_cyc_q.push_back(cyc);
    end
    if (res_valid && !prev_valid) rv_cyc_q.push_back(cyc);
    if (res_valid && prev_valid) begin
      if (res_data !== prev_data) unstable++;
      if (m_write || m_chipselect || m_address !== prev_addr) push_bus++;
    end
    if (res_valid && res_ready) res_q.push_back(res_data);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_valid = res_valid;
    prev_data  = res_data;
    prev_addr  = m_address;
  end

  // Consumer: optional stall of one result, or random readiness.
  int stall_res = -1;
  int stall_len = 0;
  int stall_cnt = 0;
  bit rand_ready = 0;

  always @(posedge clk) begin
    #1;
    if (res_valid && res_q.size() == stall_res && stall_cnt < stall_len) begin
      res_ready = 1'b0;
      stall_cnt++;
    end else if (rand_ready) begin
      res_ready = 1'($urandom_range(0, 1));
    end else begin
      res_ready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wr_q.delete();
    wr_cyc_q.delete();
    res_q.delete();
    rv_cyc_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    done_cyc = 0;
    err_cyc  = 0;
    unstable = 0;
    push_bus = 0;
  endtask

  task automatic pulse_trig(output int t0);
    @(posedge clk);
    #2 trig = 1'b1;
    @(posedge clk);
    #2 trig = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk("wait_bound", 64'(done_cnt + err_cnt), 64'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Reference: DVSR and BEN writes, then one command per read; results are
  // the slave responses in order; exactly one done.
  task automatic check_scan(input string tag);
    logic [33:0] exp_w[$];
    exp_w.push_back({2'd3, 32'd250});
    exp_w.push_back({2'd2, 32'd3});
    for (int k = 0; k < N; k++) exp_w.push_back({2'd0, CB + 32'(k)});
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_w[i]));
    chk({tag, "_nres"}, 64'(res_q.size()), 64'(N));
    for (int k = 0; k < N && k < res_q.size(); k++)
      chk($sformatf("%s_res%0d", tag, k), 64'(res_q[k]), 64'(resp[k]));
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err"}, 64'(err_cnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_stable"}, 64'(unstable), 64'd0);
    chk({tag, "_pushbus"}, 64'(push_bus), 64'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_cs"}, 64'(m_chipselect), 64'd0);
    chk({tag, "_we"}, 64'(m_write), 64'd0);
    chk({tag, "_addr"}, 64'(m_address), 64'd0);
    chk({tag, "_wdata"}, 64'(m_writedata), 64'd0);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_rdata"}, 64'(res_data), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    for (int i = 0; i < 16; i++) resp[i] = 32'hA0 + 32'(i);

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check_reset_outs("rst");
    reset = 1'b0;

    // Nominal scan.
    clr();
    pulse_trig(t0);
    chk("trig_busy", 64'(busy), 64'd1);
    chk("trig_dvsr", 64'({m_write, m_chipselect, m_address}), 64'({1'b1, 1'b1, 2'd3}));
    wait_end(1000);
    check_scan("nom");

    // Back-pressure on result 1, plus trig pulsed mid-scan.
    clr();
    stall_res = 1;
    stall_len = 20;
    stall_cnt = 0;
    pulse_trig(t0);
    repeat (15) @(posedge clk);
    #2 trig = 1'b1;
    @(posedge clk);
    #2 trig = 1'b0;
    wait_end(1000);
    check_scan("bp");
    chk("bp_stalled", 64'(stall_cnt), 64'd20);
    stall_res = -1;

    // Poll timeout, then restart.
    clr();
    idle_stuck = 1;
    pulse_trig(t0);
    wait_end(1000);
    chk("to_err", 64'(err_cnt), 64'd1);
    chk("to_done", 64'(done_cnt), 64'd0);
    chk("to_valid", 64'(rv_cyc_q.size()), 64'd0);
    chk("to_nwr", 64'(wr_q.size()), 64'd3);
    if (wr_cyc_q.size() == 3)
      chk("to_time", 64'(err_cyc - wr_cyc_q[2]), 64'(S + 1 + 2 * PL));
    chk("to_busy", 64'(busy), 64'd0);
    idle_stuck = 0;
    clr();
    pulse_trig(t0);
    chk("restart_dvsr", 64'({m_write, m_address, m_writedata}), 64'({1'b1, 2'd3, 32'd250}));
    wait_end(1000);
    check_scan("restart");

    // Immediate idle: minimum latencies.
    clr();
    idle_force = 1;
    pulse_trig(t0);
    wait_end(1000);
    chk("imm_total", 64'(done_cyc - t0), 64'(2 + N * (S + 6)));
    for (int k = 0; k < N; k++)
      if (k < rv_cyc_q.size() && k + 2 < wr_cyc_q.size())
        chk($sformatf("imm_lat%0d", k), 64'(rv_cyc_q[k] - wr_cyc_q[k + 2]), 64'(S + 5));
    check_scan("imm");
    idle_force = 0;

    // Reset while a result is pending.
    clr();
    stall_res = 0;
    stall_len = 100000;
    stall_cnt = 0;
    pulse_trig(t0);
    n = 0;
    while (!res_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_push", 64'(res_valid), 64'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_outs("midrst");
    chk("midrst_nres", 64'(res_q.size()), 64'd0);
    stall_res = -1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    clr();
    pulse_trig(t0);
    wait_end(1000);
    check_scan("postrst");

    // Randomized scans.
    rand_ready = 1;
    for (int r = 0; r < 3; r++) begin
      clr();
      for (int i = 0; i < 16; i++) resp[i] = $urandom;
      idle_delay = $urandom_range(0, 12);
      pulse_trig(t0);
      wait_end(3000);
      check_scan($sformatf("rnd%0d", r));
    end
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
